// File: rtl/selec_sequencer.sv
// Stages per-slot select entries in shadow regs and swaps them into wSelec atomically on commit.
// Commit takes DRAIN+SETTLE+2 cycles with wBusy held around the swap; cfg_ready is low outside IDLE.
module selec_sequencer #(
    parameter int MAIN_INPUTS              = 16,
    parameter int REGS_INPUTS              = 64,
    parameter int SELECTOR_OUTPUTS         = 4,
    parameter int SELECTOR_OUTPUTS_PER_BUS = 4,
    parameter int DRAIN_CYCLES             = 2,
    parameter int SETTLE_CYCLES            = 1,
    localparam int MW    = $clog2(MAIN_INPUTS),
    localparam int RW    = $clog2(REGS_INPUTS + 1),
    localparam int SEL_W = MW + RW,
    localparam int NSLOT = SELECTOR_OUTPUTS * SELECTOR_OUTPUTS_PER_BUS,
    localparam int SW    = $clog2(NSLOT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [SW-1:0]          cfg_slot,
    input  logic [SEL_W-1:0]       cfg_sel,
    input  logic                   commit_req,
    output logic                   wBusy,
    output logic [NSLOT*SEL_W-1:0] wSelec,
    output logic                   commit_done,
    output logic                   cfg_err,
    output logic [NSLOT-1:0]       dirty
);
    localparam int CMAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] REG_MAX     = RW'(REGS_INPUTS);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NSLOT*SEL_W-1:0] shadow_q, shadow_d;
    logic [NSLOT*SEL_W-1:0] live_q, live_d;
    logic [NSLOT-1:0]       dirty_q, dirty_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [RW-1:0]          reg_idx;
    logic                   entry_ok;

    always_comb begin
        reg_idx  = cfg_sel[SEL_W-1:MW];
        entry_ok = (reg_idx <= REG_MAX);
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        dirty_d  = dirty_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (entry_ok) begin
                        shadow_d[cfg_slot*SEL_W +: SEL_W] = cfg_sel;
                        dirty_d[cfg_slot] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A commit with nothing staged completes without disturbing the datapath.
                if (commit_req) begin
                    if (dirty_q == '0 && !(cfg_valid && entry_ok)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = SWAP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            SWAP: begin
                live_d  = shadow_q;
                dirty_d = '0;
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            live_q   <= '0;
            dirty_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
            dirty_q  <= dirty_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign wBusy       = busy_q;
    assign wSelec      = live_q;
    assign commit_done = done_q;
    assign cfg_err     = err_q;
    assign dirty       = dirty_q;
endmodule

// File: tb/tb_selec_sequencer.sv
// Directed bench for selec_sequencer; commit/err responses are queued and checked by a monitor.
module tb_selec_sequencer;
    localparam int SEL_W = 11;
    localparam int NSLOT = 16;
    localparam int W     = NSLOT * SEL_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [3:0]       cfg_slot = '0;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic             commit_req = 1'b0;
    logic             wBusy;
    logic [W-1:0]     wSelec;
    logic             commit_done;
    logic             cfg_err;
    logic [NSLOT-1:0] dirty;

    selec_sequencer dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_slot(cfg_slot), .cfg_sel(cfg_sel), .commit_req(commit_req),
        .wBusy(wBusy), .wSelec(wSelec), .commit_done(commit_done),
        .cfg_err(cfg_err), .dirty(dirty)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int               edge_no;
        logic [W-1:0]     wsel;
        logic [NSLOT-1:0] dirty;
    } done_t;

    done_t done_q[$];
    int    err_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    logic [SEL_W-1:0] m_sh[NSLOT];
    logic [NSLOT-1:0] m_dirty;
    logic [W-1:0]     m_live;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] shadow_vec();
        logic [W-1:0] v;
        for (int k = 0; k < NSLOT; k++) v[k*SEL_W +: SEL_W] = m_sh[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NSLOT; k++) m_sh[k] = '0;
        m_dirty = '0;
        m_live  = '0;
    endtask

    task automatic wr(input int slot, input logic [SEL_W-1:0] val);
        cfg_valid = 1'b1;
        cfg_slot  = slot[3:0];
        cfg_sel   = val;
        if (val[10:4] > 7'd64) err_q.push_back(edge_cnt + 1);
        else begin
            m_sh[slot]    = val;
            m_dirty[slot] = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
        chk("dirty_after_write", dirty, m_dirty);
    endtask

    task automatic commit(input bit with_wr, input int slot, input logic [SEL_W-1:0] val,
                          input bit disturb, input string tag);
        logic [W-1:0] old_live, new_live;
        bit           busy;
        int           t;
        commit_req = 1'b1;
        t = edge_cnt + 1;
        if (with_wr) begin
            cfg_valid = 1'b1;
            cfg_slot  = slot[3:0];
            cfg_sel   = val;
            if (val[10:4] > 7'd64) err_q.push_back(t);
            else begin
                m_sh[slot]    = val;
                m_dirty[slot] = 1'b1;
            end
        end
        busy     = (m_dirty != '0);
        old_live = m_live;
        new_live = busy ? shadow_vec() : m_live;
        done_q.push_back('{t + (busy ? 4 : 0), new_live, '0});
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 0) begin
                commit_req = 1'b0;
                cfg_valid  = 1'b0;
                if (disturb) begin
                    cfg_valid  = 1'b1;
                    cfg_slot   = 4'd1;
                    cfg_sel    = 11'h123;
                    commit_req = 1'b1;
                end
            end
            chk({tag, "_wbusy"}, wBusy, busy && j <= 3);
            chk({tag, "_wselec"}, wSelec, (busy && j >= 3) ? new_live : old_live);
            chk({tag, "_cfg_ready"}, cfg_ready, !busy || j == 4);
            if (j == 3) begin
                cfg_valid  = 1'b0;
                commit_req = 1'b0;
            end
        end
        m_live = new_live;
        if (busy) m_dirty = '0;
    endtask

    // Monitor: every done/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (commit_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                done_t e;
                e = done_q.pop_front();
                chk("done_edge", edge_cnt, e.edge_no);
                chk("done_wselec", wSelec, e.wsel);
                chk("done_dirty", dirty, e.dirty);
                chk("done_wbusy", wBusy, 0);
            end
        end
        if (cfg_err) begin
            if (err_q.size() == 0) chk("err_unexpected", 1, 0);
            else chk("err_edge", edge_cnt, err_q.pop_front());
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_wselec", wSelec, '0);
        chk("rst_wbusy", wBusy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_dirty", dirty, '0);
        chk("rst_done", commit_done, 0);
        chk("rst_err", cfg_err, 0);

        wr(3, 11'h059);
        commit(0, 0, '0, 0, "c_slot3");
        chk("slot3_value", wSelec[3*SEL_W +: SEL_W], 11'h059);
        chk("slot3_others_zero", wSelec & ~({{(W-SEL_W){1'b0}}, {SEL_W{1'b1}}} << (3*SEL_W)), '0);

        wr(0, 11'h410);
        chk("reg65_dirty0", dirty[0], 0);
        wr(0, 11'h400);
        chk("reg64_dirty0", dirty[0], 1);

        wr(15, 11'h7FF);
        wr(15, 11'h40F);
        commit(1, 2, 11'h012, 0, "c_with_wr");
        chk("slot15_value", wSelec[15*SEL_W +: SEL_W], 11'h40F);
        chk("slot2_value", wSelec[2*SEL_W +: SEL_W], 11'h012);
        chk("slot0_value", wSelec[0 +: SEL_W], 11'h400);

        commit(0, 0, '0, 0, "c_noop");

        wr(4, 11'h0AB);
        commit(0, 0, '0, 1, "c_disturb");
        chk("disturb_dirty1", dirty[1], 0);
        chk("disturb_slot1", wSelec[1*SEL_W +: SEL_W], '0);
        repeat (3) tick();
        chk("disturb_no_busy", wBusy, 0);

        wr(6, 11'h001);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("mid_drain_busy", wBusy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wselec", wSelec, '0);
        chk("mid_rst_wbusy", wBusy, 0);
        chk("mid_rst_dirty", dirty, '0);
        chk("mid_rst_done", commit_done, 0);
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        repeat (6) tick();
        chk("post_rst_wselec", wSelec, '0);
        chk("post_rst_ready", cfg_ready, 1);
        commit(0, 0, '0, 0, "c_post_rst");

        repeat (3) tick();
        chk("done_queue_empty", done_q.size(), 0);
        chk("err_queue_empty", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
